// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - 8-digit seven-segment scan controller with per-frame value capture
module seg_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic [7:0]  en_mask,
  input  logic        blank_lz,
  output logic [3:0]  digit_out,
  output logic [7:0]  anodes,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       anodes_q, anodes_d;
  logic [3:0]       digit_q, digit_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic             wrap;
  logic [7:0]       nib_zero;
  logic [7:0]       upper_zero;
  logic [7:0]       lead_zero;
  logic             visible;

  // Prescaler: free-running counter that wraps after REFRESH_DIV cycles.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Scan index and frame capture; the 7->0 step is the only point the shadow reloads.
  always_comb begin
    idx_d    = idx_q;
    wrap     = 1'b0;
    shadow_d = shadow_q;
    if (tick) begin
      idx_d = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
      wrap  = (idx_q == 3'd7);
    end
    if (wrap) begin
      shadow_d = value;
    end
  end

  // Leading-zero map: digit i is blank when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    nib_zero   = '0;
    upper_zero = '0;
    for (int i = 0; i < 8; i++) begin
      nib_zero[i] = (shadow_d[i*4 +: 4] == 4'h0);
    end
    upper_zero[7] = nib_zero[7];
    for (int i = 6; i >= 0; i--) begin
      upper_zero[i] = nib_zero[i] & upper_zero[i+1];
    end
    lead_zero = blank_lz ? {upper_zero[7:1], 1'b0} : 8'h00;
  end

  // Next output values, computed from the new index and new shadow so they change together with idx.
  always_comb begin
    visible     = en_mask[idx_d] & ~lead_zero[idx_d];
    anodes_d    = anodes_q;
    digit_d     = digit_q;
    frame_d     = wrap;
    if (tick) begin
      digit_d  = shadow_d[{idx_d, 2'b00} +: 4];
      anodes_d = visible ? ~(8'h01 << idx_d) : 8'hFF;
    end
  end

  // State and registered outputs; idx starts at 7 so the first tick is a capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= 3'd7;
      shadow_q <= 32'h0;
      anodes_q <= 8'hFF;
      digit_q  <= 4'h0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      anodes_q <= anodes_d;
      digit_q  <= digit_d;
      frame_q  <= frame_d;
    end
  end

  assign digit_out   = digit_q;
  assign anodes      = anodes_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - scoreboard bench for seg_scan_mux at REFRESH_DIV 4 and 1
module tb_seg_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [31:0] value_a, value_b;
  logic [7:0]  en_a, en_b;
  logic        blz_a, blz_b;
  logic [3:0]  digit_a, digit_b;
  logic [7:0]  anodes_a, anodes_b;
  logic        fs_a, fs_b;

  seg_scan_mux #(.REFRESH_DIV(4)) dut_a (
    .clk(clk), .reset(rst_a), .value(value_a), .en_mask(en_a), .blank_lz(blz_a),
    .digit_out(digit_a), .anodes(anodes_a), .frame_start(fs_a)
  );

  seg_scan_mux #(.REFRESH_DIV(1)) dut_b (
    .clk(clk), .reset(rst_b), .value(value_b), .en_mask(en_b), .blank_lz(blz_b),
    .digit_out(digit_b), .anodes(anodes_b), .frame_start(fs_b)
  );

  localparam logic [12:0] RST_OUT = {8'hFF, 4'h0, 1'b0};

  int n_checks = 0;
  int n_errors = 0;
  int de = 0;
  logic [12:0] exp_a[$];
  logic [12:0] exp_b[$];

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s @%0t: got anodes=%h digit=%h fs=%b, want anodes=%h digit=%h fs=%b",
               name, $time, got[12:5], got[4:1], got[0], want[12:5], want[4:1], want[0]);
    end
  endtask

  // Push one frame (or its first n slots) of expectations; an/dg are listed slot 7 .. slot 0.
  task automatic push_frame(input bit sel_b, input logic [63:0] an, input logic [31:0] dg, input int n);
    for (int s = 0; s < n; s++) begin
      logic [12:0] e;
      e = {an[s*8 +: 8], dg[s*4 +: 4], (s == 0)};
      if (sel_b) exp_b.push_back(e);
      else       exp_a.push_back(e);
    end
  endtask

  task automatic adv_to(input int e);
    while (de < e) begin
      @(posedge clk);
      de++;
    end
    #2;
  endtask

  // Monitor A: every 4th cycle after reset release is a tick; in between outputs must hold.
  initial begin : mon_a
    int cyc;
    logic [12:0] hold;
    logic [12:0] e;
    cyc  = 0;
    hold = RST_OUT;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        cyc  = 0;
        hold = RST_OUT;
      end else begin
        cyc++;
        if (cyc % 4 == 0) begin
          if (exp_a.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL a_underflow @%0t: got anodes=%h, want no output event", $time, anodes_a);
          end else begin
            e = exp_a.pop_front();
            chk("a_slot", {anodes_a, digit_a, fs_a}, e);
            hold = {e[12:1], 1'b0};
          end
        end else begin
          chk("a_hold", {anodes_a, digit_a, fs_a}, hold);
        end
      end
    end
  end

  // Monitor B: a tick on every cycle, and never more than one anode low.
  initial begin : mon_b
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        n_checks++;
        if ($countones(~anodes_b) > 1) begin
          n_errors++;
          $display("FAIL b_onehot @%0t: got anodes=%h, want at most one low", $time, anodes_b);
        end
        if (exp_b.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL b_underflow @%0t: got anodes=%h, want no output event", $time, anodes_b);
        end else begin
          e = exp_b.pop_front();
          chk("b_slot", {anodes_b, digit_b, fs_b}, e);
        end
      end
    end
  end

  initial begin : driver
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    value_a = 32'h12345678;
    en_a    = 8'hFF;
    blz_a   = 1'b0;
    value_b = 32'h12345678;
    en_b    = 8'hFF;
    blz_b   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("a_reset", {anodes_a, digit_a, fs_a}, RST_OUT);
    chk("b_reset", {anodes_b, digit_b, fs_b}, RST_OUT);

    // REFRESH_DIV=1: three back-to-back frames, one digit per cycle
    for (int f = 0; f < 3; f++) push_frame(1'b1, 64'h7FBFDFEFF7FBFDFE, 32'h12345678, 8);
    @(negedge clk);
    #2 rst_b = 1'b0;
    repeat (24) @(posedge clk);
    @(negedge clk);
    #2 rst_b = 1'b1;
    n_checks++;
    if (exp_b.size() != 0) begin
      n_errors++;
      $display("FAIL b_drain: got %0d pending, want 0", exp_b.size());
    end

    // REFRESH_DIV=4: normal scan, then tearing test, then async reset while digit 5 is lit
    push_frame(1'b0, 64'h7FBFDFEFF7FBFDFE, 32'h12345678, 8);
    push_frame(1'b0, 64'h7FBFDFEFF7FBFDFE, 32'h12345678, 8);
    push_frame(1'b0, 64'h7FBFDFEFF7FBFDFE, 32'hAAAAAAAA, 6);
    @(negedge clk);
    #2 rst_a = 1'b0;
    de = 0;
    adv_to(4 * 12 + 1);
    value_a = 32'hAAAAAAAA;
    adv_to(4 * 22 + 1);
    #1 rst_a = 1'b1;
    #1 chk("a_async_reset", {anodes_a, digit_a, fs_a}, RST_OUT);

    // Leading-zero blanking, all-zero value, then partial enable mask
    value_a = 32'h00000A05;
    blz_a   = 1'b1;
    push_frame(1'b0, 64'hFFFFFFFFFFFBFDFE, 32'h00000A05, 8);
    push_frame(1'b0, 64'hFFFFFFFFFFFFFFFE, 32'h00000000, 8);
    push_frame(1'b0, 64'hFFFFFFFFF7FBFDFE, 32'h87654321, 8);
    push_frame(1'b0, 64'hFFFFFFFFF7FBFDFE, 32'h87654321, 8);
    repeat (2) @(negedge clk);
    #2 rst_a = 1'b0;
    de = 0;
    adv_to(4 * 4 + 1);
    value_a = 32'h00000000;
    adv_to(4 * 16 + 1);
    en_a    = 8'h0F;
    blz_a   = 1'b0;
    value_a = 32'h87654321;
    adv_to(4 * 32 + 1);
    n_checks++;
    if (exp_a.size() != 0) begin
      n_errors++;
      $display("FAIL a_drain: got %0d pending, want 0", exp_a.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Time-multiplexed scan controller for the 8-digit common-anode seven-segment display. It sits directly upstream of the BCD/hex-to-seven-segment decoder.
- Holds a 32-bit display value (8 nibbles).
- Steps through the digits at a programmable refresh rate.
- Presents the current nibble to the decoder and drives the active-low anode lines.
- Supports per-digit enable and leading-zero blanking.
- Captures the display value once per frame to prevent tearing.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (100 MHz clock → 1 kHz per digit); legal range ≥1.
CNT_W, $clog2(REFRESH_DIV)+1, prescaler counter width (derived, not overridden).

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
value  in  32  display value; nibble i drives digit i (digit 0 = rightmost, value[3:0]).
en_mask  in  8  per-digit enable; bit i = 1 allows digit i to light.
blank_lz  in  1  1 = blank leading zero digits.
digit_out  out  4  nibble for the decoder input.
anodes  out  8  active-low anode enables, at most one bit low.
frame_start  out  1  one-cycle pulse on the edge where scanning moves to digit 0.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-scan):
  - prescaler cnt=0, idx=7, shadow=32'h0.
  - anodes=8'hFF, digit_out=4'h0, frame_start=0.
- Prescaler:
  - cnt increments every cycle.
  - tick is asserted when cnt==REFRESH_DIV-1; cnt returns to 0 on that edge.
  - REFRESH_DIV=1 gives a tick every cycle.
- Scan index: on each tick edge, idx <= (idx==7) ? 0 : idx+1. It wraps modulo 8.
- Frame capture: on the tick edge where idx goes 7→0, shadow <= value and frame_start=1 for exactly that following cycle. The first tick after reset is therefore a capture.
- Tearing: value changes between captures have no effect until the next 7→0 transition.
- Registered outputs (all updated on the tick edge, from the new idx and the new shadow):
  - digit_out = shadow nibble at new idx.
  - anodes = all ones, except bit new_idx = 0 when that digit is visible.
  - Latency: outputs reflect the new digit on the same edge idx changes; they are stable between ticks.
- Visibility of digit i requires both:
  - en_mask[i]=1, sampled on the tick edge.
  - It is not a leading zero.
- Leading zero definition: digit i is a leading zero when blank_lz=1 and shadow nibbles i..7 are all 4'h0.
  - Digit 0 is never a leading zero, so value 0 displays a single "0".
  - Interior zeros stay lit.
- Invisible digit: anodes=8'hFF for that slot, but digit_out still carries the nibble. The slot time is consumed, not skipped, so the frame period is always 8×REFRESH_DIV cycles.
- en_mask and blank_lz changes take effect at the next tick. No capture is needed.
- Between reset release and the first tick, anodes stay 8'hFF.
- No combinational path from inputs to outputs.

Test Plan:
1. REFRESH_DIV=4, value=32'h12345678, en_mask=8'hFF, blank_lz=0, release reset.
   → On the 4th rising edge: anodes=8'hFE, digit_out=4'h8, frame_start=1 for one cycle.
   → Every 4 cycles after that: anodes FD/3'h7, FB/6, … up to 7F/1.
   → Then FE/8 again with frame_start=1.
2. Same setup; change value to 32'hAAAAAAAA while digit 3 is lit.
   → Digits 4–7 still show 4,3,2,1.
   → All digits show A only after the next frame_start.
3. value=32'h00000A05, blank_lz=1.
   → Digits 0,1,2 light with 5,0,A.
   → Slots 3–7: anodes=8'hFF.
   → value=0: only digit 0 lit, showing 0.
4. en_mask=8'h0F, value=32'h87654321.
   → Digits 0–3 lit (1,2,3,4); slots 4–7 dark.
   → Frame period stays 32 cycles.
5. Assert reset asynchronously (not clock-aligned) while digit 5 is lit.
   → Immediately: anodes=8'hFF, digit_out=0.
   → After release: first lit digit is 0, after REFRESH_DIV cycles.
6. REFRESH_DIV=1.
   → anodes advance every cycle.
   → frame_start pulses every 8 cycles.
   → Never more than one anode low.
